charram_write_arbiter: RTL

//  Owns write port A of the text-mode character RAM (128 cols x 64 rows, 7-bit codes).

---
 rtl/charram_pkg.sv | 26 ++
 rtl/charram_write_arbiter_if.sv | 27 ++
 rtl/charram_clear_engine.sv | 74 +++++++
 rtl/charram_write_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/charram_pkg.sv
// Shared constants, clear FSM encoding and helpers for the character RAM write path.
package charram_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = ADDR_W - COL_W;
  // One extra bit so the last-cell compare never wraps.
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam int unsigned ROW_CELLS    = 2 ** COL_W;
  localparam int unsigned SCREEN_CELLS = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] FILL_CHAR = 7'h00;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

  // Final counter value of a clear: one row or the whole screen.
  function automatic logic [CNT_W-1:0] clear_last(input logic row_en);
    return row_en ? CNT_W'(ROW_CELLS - 1) : CNT_W'(SCREEN_CELLS - 1);
  endfunction

endpackage

// File: rtl/charram_write_arbiter_if.sv
// KEY/AUX write request handshake bundle; requesters hold req until they see ack.
interface charram_write_arbiter_if;
  import charram_pkg::*;

  logic              key_req;
  logic [ADDR_W-1:0] key_addr;
  logic [DATA_W-1:0] key_char;
  logic              key_ack;

  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_char;
  logic              aux_ack;

  modport master (
    output key_req, key_addr, key_char,
    output aux_req, aux_addr, aux_char,
    input  key_ack, aux_ack
  );

  modport slave (
    input  key_req, key_addr, key_char,
    input  aux_req, aux_addr, aux_char,
    output key_ack, aux_ack
  );

endinterface

// File: rtl/charram_clear_engine.sv
// Clear engine: sweeps one row or the whole screen, one cell per cycle, writing FillChar.
module charram_clear_engine
  import charram_pkg::*;
#(
  parameter logic [DATA_W-1:0] FillChar = FILL_CHAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  input  logic              clr_row_en,
  input  logic [ROW_W-1:0]  clr_row,
  output logic              clr_busy,
  output logic              clr_done,
  // Requesters must stall while this is high (clear running or finishing).
  output logic              clr_hold,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_din
);

  clr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             row_en_q;
  logic [ROW_W-1:0] row_q;
  // last_q marks the cycle the final write is on the RAM port; done_q follows it.
  logic             last_q;
  logic             done_q;

  // Clear FSM, counter and done sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      row_en_q <= 1'b0;
      row_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      last_q <= 1'b0;
      done_q <= last_q;
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            row_en_q <= clr_row_en;
            row_q    <= clr_row;
          end
        end
        StClear: begin
          if (cnt_q == clear_last(row_en_q)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Clear write request toward the output register.
  always_comb begin
    clr_we   = (state_q == StClear);
    clr_addr = row_en_q ? {row_q, cnt_q[COL_W-1:0]} : cnt_q[ADDR_W-1:0];
    clr_din  = FillChar;
  end

  assign clr_busy = (state_q == StClear);
  assign clr_done = done_q;
  assign clr_hold = clr_busy | last_q | done_q;

endmodule

// File: rtl/charram_write_arbiter.sv
// Write-port-A owner for the character RAM: clear engine first, then KEY/AUX round-robin.
module charram_write_arbiter
  import charram_pkg::*;
#(
  parameter logic [DATA_W-1:0] FillChar = FILL_CHAR
) (
  input  logic                    clk,
  input  logic                    reset,
  charram_write_arbiter_if.slave  req_if,
  input  logic                    clr_start,
  input  logic                    clr_row_en,
  input  logic [ROW_W-1:0]        clr_row,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din
);

  logic              clr_hold;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_din;

  // 0 favours KEY, 1 favours AUX; only moves when both contend.
  logic rr_q;
  logic key_gnt;
  logic aux_gnt;
  logic both_req;

  charram_clear_engine #(
    .FillChar (FillChar)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clr_start  (clr_start),
    .clr_row_en (clr_row_en),
    .clr_row    (clr_row),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clr_hold   (clr_hold),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .clr_din    (clr_din)
  );

  assign both_req = req_if.key_req & req_if.aux_req;

  // Combinational grant; nothing is granted in reset or while the clear owns the port.
  always_comb begin
    key_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (reset && !clr_hold) begin
      if (both_req) begin
        key_gnt = ~rr_q;
        aux_gnt = rr_q;
      end else begin
        key_gnt = req_if.key_req;
        aux_gnt = req_if.aux_req;
      end
    end
  end

  assign req_if.key_ack = key_gnt;
  assign req_if.aux_ack = aux_gnt;

  // Round-robin pointer: after a contended grant, favour the side that lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (both_req && !clr_hold) begin
      rr_q <= key_gnt;
    end
  end

  // Registered RAM port A; address/data hold their last value when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= clr_we | key_gnt | aux_gnt;
      if (clr_we) begin
        ram_addr <= clr_addr;
        ram_din  <= clr_din;
      end else if (key_gnt) begin
        ram_addr <= req_if.key_addr;
        ram_din  <= req_if.key_char;
      end else if (aux_gnt) begin
        ram_addr <= req_if.aux_addr;
        ram_din  <= req_if.aux_char;
      end
    end
  end

endmodule
